// File: rtl/sm3_pkg.sv
// Shared SM3 padding definitions: FSM states, block geometry and pad constants.
package sm3_pkg;

  localparam int unsigned SM3_BLK_WORDS = 16;
  localparam int unsigned SM3_LEN_IDX   = 14;
  localparam int unsigned SM3_IDX_W     = $clog2(SM3_BLK_WORDS);
  localparam int unsigned SM3_WORD_W    = 32;
  localparam int unsigned SM3_LEN_W     = 64;

  localparam logic [SM3_WORD_W-1:0] SM3_PAD_WORD = 32'h8000_0000;
  localparam logic [7:0]            SM3_PAD_BYTE = SM3_PAD_WORD[31:24];

  typedef enum logic [2:0] {
    S_MSG,
    S_ONE,
    S_ZERO,
    S_LENH,
    S_LENL
  } sm3_state_e;

  // Bits contributed by the last word; byte_num 0 means a full word.
  function automatic logic [SM3_LEN_W-1:0] sm3_last_bits(input logic [1:0] byte_num);
    return (byte_num == 2'd0) ? SM3_LEN_W'(32) : SM3_LEN_W'({byte_num, 3'b000});
  endfunction

endpackage

// File: rtl/sm3_pad_byte_ins.sv
// Last-word 0x80 insertion: keeps the valid left-aligned bytes, drops the rest.
module sm3_pad_byte_ins
  import sm3_pkg::*;
(
  input  logic [SM3_WORD_W-1:0] word_i,
  input  logic [1:0]            byte_num_i,
  output logic [SM3_WORD_W-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    case (byte_num_i)
      2'd1:    word_o = {word_i[31:24], SM3_PAD_BYTE, 16'h0000};
      2'd2:    word_o = {word_i[31:16], SM3_PAD_BYTE, 8'h00};
      2'd3:    word_o = {word_i[31:8],  SM3_PAD_BYTE};
      default: word_o = word_i;
    endcase
  end

endmodule

// File: rtl/sm3_msg_pad.sv
// SM3 message padder: forwards message words, then emits 0x80, zero fill and
// the 64-bit bit length so the stream ends on a 16-word block boundary.
module sm3_msg_pad
  import sm3_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SM3_WORD_W-1:0] msg_inpt_d_i,
  input  logic                  msg_inpt_vld_i,
  input  logic                  msg_inpt_lst_i,
  input  logic [1:0]            msg_inpt_byte_num_i,
  output logic                  msg_inpt_rdy_o,
  output logic [SM3_WORD_W-1:0] pad_otpt_d_o,
  output logic                  pad_otpt_vld_o,
  output logic                  pad_otpt_lst_o
);

  localparam logic [SM3_IDX_W-1:0] LEN_IDX = SM3_IDX_W'(SM3_LEN_IDX);

  sm3_state_e             state_q, state_d;
  logic [SM3_IDX_W-1:0]   idx_q, idx_d, idx_inc;
  logic [SM3_LEN_W-1:0]   len_q, len_d;
  logic [SM3_WORD_W-1:0]  d_q, d_d;
  logic                   vld_q, vld_d;
  logic                   lst_q, lst_d;
  logic [SM3_WORD_W-1:0]  ins_word;
  logic                   accept;

  assign msg_inpt_rdy_o = (state_q == S_MSG);
  assign accept         = msg_inpt_vld_i && msg_inpt_rdy_o;
  assign idx_inc        = idx_q + SM3_IDX_W'(1);

  sm3_pad_byte_ins u_byte_ins (
    .word_i     (msg_inpt_d_i),
    .byte_num_i (msg_inpt_byte_num_i),
    .word_o     (ins_word)
  );

  // Next-state, index/length bookkeeping and the word to present next cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    d_d     = '0;
    vld_d   = 1'b0;
    lst_d   = 1'b0;
    case (state_q)
      S_MSG: begin
        if (accept) begin
          vld_d = 1'b1;
          idx_d = idx_inc;
          if (msg_inpt_lst_i) begin
            d_d   = ins_word;
            len_d = len_q + sm3_last_bits(msg_inpt_byte_num_i);
            if (msg_inpt_byte_num_i == 2'd0) begin
              state_d = S_ONE;
            end else begin
              state_d = (idx_inc == LEN_IDX) ? S_LENH : S_ZERO;
            end
          end else begin
            d_d   = msg_inpt_d_i;
            len_d = len_q + SM3_LEN_W'(32);
          end
        end
      end
      S_ONE: begin
        vld_d   = 1'b1;
        d_d     = SM3_PAD_WORD;
        idx_d   = idx_inc;
        state_d = (idx_inc == LEN_IDX) ? S_LENH : S_ZERO;
      end
      S_ZERO: begin
        vld_d = 1'b1;
        idx_d = idx_inc;
        if (idx_inc == LEN_IDX) begin
          state_d = S_LENH;
        end
      end
      S_LENH: begin
        vld_d   = 1'b1;
        d_d     = len_q[63:32];
        idx_d   = idx_inc;
        state_d = S_LENL;
      end
      S_LENL: begin
        vld_d   = 1'b1;
        lst_d   = 1'b1;
        d_d     = len_q[31:0];
        idx_d   = '0;
        len_d   = '0;
        state_d = S_MSG;
      end
      default: state_d = S_MSG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_MSG;
      idx_q   <= '0;
      len_q   <= '0;
      d_q     <= '0;
      vld_q   <= 1'b0;
      lst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      d_q     <= d_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
    end
  end

  assign pad_otpt_d_o   = d_q;
  assign pad_otpt_vld_o = vld_q;
  assign pad_otpt_lst_o = lst_q;

endmodule

// File: tb/tb_sm3_msg_pad.sv
// Self-checking bench for sm3_msg_pad against a byte-level padding model.
module tb_sm3_msg_pad;

  logic        clk;
  logic        rst;
  logic [31:0] msg_d;
  logic        msg_vld;
  logic        msg_lst;
  logic [1:0]  msg_bn;
  logic        msg_rdy;
  logic [31:0] pad_d;
  logic        pad_vld;
  logic        pad_lst;

  int checks;
  int errors;
  bit flush;

  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [31:0] wd[$];

  sm3_msg_pad dut (
    .clk                 (clk),
    .rst                 (rst),
    .msg_inpt_d_i        (msg_d),
    .msg_inpt_vld_i      (msg_vld),
    .msg_inpt_lst_i      (msg_lst),
    .msg_inpt_byte_num_i (msg_bn),
    .msg_inpt_rdy_o      (msg_rdy),
    .pad_otpt_d_o        (pad_d),
    .pad_otpt_vld_o      (pad_vld),
    .pad_otpt_lst_o      (pad_lst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'h61 + 8'(i % 4);
  endfunction

  // Padding model at byte level: msg || 0x80 || zeros || 64-bit length.
  function automatic void model(input int n, output logic [31:0] w[$]);
    logic [7:0]  b[$];
    logic [63:0] len;
    w = {};
    for (int i = 0; i < n; i++) b.push_back(pat(i));
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    len = 64'(n) * 64'd8;
    for (int i = 7; i >= 0; i--) b.push_back(len[8*i +: 8]);
    for (int k = 0; k < b.size() / 4; k++)
      w.push_back({b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
  endfunction

  task automatic send_msg(input int n, input bit gaps, input bit hold, input logic [31:0] w[$]);
    int nw;
    int cnt;
    bit acc;
    int idx;
    logic [31:0] word;
    nw = (n + 3) / 4;
    foreach (w[i]) begin
      exp_d.push_back(w[i]);
      exp_l.push_back(i == w.size() - 1);
    end
    for (int k = 0; k < nw; k++) begin
      word = '0;
      for (int j = 0; j < 4; j++) begin
        idx  = 4 * k + j;
        word = {word[23:0], (idx < n) ? pat(idx) : 8'hA5};
      end
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          msg_vld = 1'b0;
          @(posedge clk); #1;
        end
      end
      msg_d   = word;
      msg_vld = 1'b1;
      msg_lst = (k == nw - 1);
      msg_bn  = 2'(n % 4);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        acc = msg_rdy;
        @(posedge clk); #1;
      end
      chk("accept", 64'(acc), 64'd1);
      if (k == 0) chk("first_latency_vld", 64'(pad_vld), 64'd1);
    end
    if (hold) begin
      msg_vld = 1'b1;
      msg_d   = 32'hDEADBEEF;
      msg_lst = 1'b0;
    end else begin
      msg_vld = 1'b0;
      msg_lst = 1'b0;
    end
    cnt = 0;
    while (!pad_lst && cnt < 64) begin
      @(posedge clk); #1;
      cnt++;
    end
    msg_vld = 1'b0;
    msg_lst = 1'b0;
    chk("tail_cycles", 64'(cnt), 64'(w.size() - nw));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    msg_vld = 1'b0;
    msg_lst = 1'b0;
    rst     = 1'b1;
    flush   = 1'b1;
    exp_d.delete();
    exp_l.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_vld", 64'(pad_vld), 64'd0);
    chk("rst_lst", 64'(pad_lst), 64'd0);
    chk("rst_d", 64'(pad_d), 64'd0);
    chk("rst_rdy", 64'(msg_rdy), 64'd1);
    flush = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    flush   = 1'b1;
    msg_d   = '0;
    msg_vld = 1'b0;
    msg_lst = 1'b0;
    msg_bn  = '0;

    fork
      forever begin
        @(negedge clk);
        if (!flush && pad_vld) begin
          if (exp_d.size() == 0) begin
            chk("extra_word", 64'(pad_d), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk("word", 64'(pad_d), 64'(exp_d.pop_front()));
            chk("lst", 64'(pad_lst), 64'(exp_l.pop_front()));
          end
        end else if (!flush && pad_lst) begin
          chk("lst_without_vld", 64'(pad_lst), 64'd0);
        end
      end
    join_none

    @(posedge clk); #1;
    do_reset();

    // "abc"
    model(3, wd);
    chk("model_abc_len", 64'(wd.size()), 64'd16);
    chk("model_abc_w0", 64'(wd[0]), 64'h6162_6380);
    chk("model_abc_w14", 64'(wd[14]), 64'h0);
    chk("model_abc_w15", 64'(wd[15]), 64'h18);
    send_msg(3, 1'b0, 1'b0, wd);

    // 64 bytes, full last word
    model(64, wd);
    chk("model_64_len", 64'(wd.size()), 64'd32);
    chk("model_64_w16", 64'(wd[16]), 64'h8000_0000);
    chk("model_64_w31", 64'(wd[31]), 64'h200);
    send_msg(64, 1'b0, 1'b0, wd);

    // 56 bytes: 0x80 word lands at index 14
    model(56, wd);
    chk("model_56_len", 64'(wd.size()), 64'd32);
    chk("model_56_w14", 64'(wd[14]), 64'h8000_0000);
    chk("model_56_w31", 64'(wd[31]), 64'h1C0);
    send_msg(56, 1'b0, 1'b0, wd);

    // 55 bytes: 0x80 in last lane of index 13, length follows immediately
    model(55, wd);
    chk("model_55_len", 64'(wd.size()), 64'd16);
    chk("model_55_w13", 64'(wd[13]), 64'h6162_6380);
    chk("model_55_w15", 64'(wd[15]), 64'h1B8);
    send_msg(55, 1'b0, 1'b0, wd);

    // Partial last word at index 15 wraps into a second block
    model(62, wd);
    send_msg(62, 1'b0, 1'b0, wd);
    model(60, wd);
    send_msg(60, 1'b0, 1'b0, wd);
    model(1, wd);
    send_msg(1, 1'b0, 1'b0, wd);

    // Random input gaps and vld held high through padding
    model(21, wd);
    send_msg(21, 1'b1, 1'b1, wd);
    model(40, wd);
    send_msg(40, 1'b1, 1'b1, wd);

    // Abort during zero fill, then a clean "abc"
    model(3, wd);
    foreach (wd[i]) begin
      exp_d.push_back(wd[i]);
      exp_l.push_back(i == wd.size() - 1);
    end
    msg_d   = 32'h6162_63A5;
    msg_vld = 1'b1;
    msg_lst = 1'b1;
    msg_bn  = 2'd3;
    @(posedge clk); #1;
    msg_vld = 1'b0;
    msg_lst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("post_abort_quiet", 64'(pad_vld), 64'd0);
    model(3, wd);
    send_msg(3, 1'b0, 1'b0, wd);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_d.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm3_msg_pad.md
SM3_MSG_PAD -- requirements
Module: sm3_msg_pad

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 msg_inpt_d_i  input  32  message word, big-endian, first byte in [31:24].
REQ-005 msg_inpt_vld_i  input  1  message word valid.
REQ-006 msg_inpt_lst_i  input  1  qualifies the last word of the message.
REQ-007 msg_inpt_byte_num_i  input  2  valid bytes in last word: 0=4, 1..3=count, left-aligned; ignored unless lst.
REQ-008 msg_inpt_rdy_o  output  1  block accepts a word this cycle.
REQ-009 pad_otpt_d_o  output  32  padded stream word.
REQ-010 pad_otpt_vld_o  output  1  pad_otpt_d_o valid; no downstream backpressure.
REQ-011 pad_otpt_lst_o  output  1  high with the final word (length low word) of the last block.

Function
REQ-012 A word SHALL be accepted only when msg_inpt_vld_i and msg_inpt_rdy_o are both high; vld while rdy is low SHALL be ignored.
REQ-013 msg_inpt_rdy_o SHALL be combinational: high only in state S_MSG.
REQ-014 States: S_MSG, S_ONE, S_ZERO, S_LENH, S_LENL.
REQ-015 Every accepted word SHALL appear on pad_otpt_d_o with vld high exactly one cycle after acceptance; pad words SHALL be emitted back-to-back, one per cycle.
REQ-016 A 4-bit word index SHALL increment per emitted word, wrapping 15->0 (block boundary).
REQ-017 A 64-bit bit-length counter SHALL add 32 per non-last word and 8*bytes on the last word, modulo 2^64, and clear after S_LENL.
REQ-018 Last word with 1..3 bytes: the byte following the valid bytes SHALL be 0x80, remaining bytes 0x00, regardless of input contents in those lanes.
REQ-019 Last word with 4 bytes: next state S_ONE, emitting 0x80000000.
REQ-020 After the word carrying 0x80: next state S_LENH if the next index is 14, else S_ZERO.
REQ-021 S_ZERO SHALL emit 0x00000000 until the next index is 14, then go to S_LENH (this spans a block boundary when 0x80 lands at index 14 or 15).
REQ-022 S_LENH SHALL emit length[63:32] at index 14; S_LENL SHALL emit length[31:0] at index 15 with pad_otpt_lst_o high, then return to S_MSG.
REQ-023 pad_otpt_lst_o SHALL be high for exactly one cycle per message.
REQ-024 Empty messages are not supported; every message carries at least one byte.

Reset
REQ-025 On rst: state S_MSG, word index 0, length 0, pad_otpt_vld_o 0, pad_otpt_lst_o 0, pad_otpt_d_o 0.
REQ-026 rst mid-message or mid-padding SHALL abort with no further output words; msg_inpt_rdy_o SHALL be high in the cycle after rst deasserts.

Structure
REQ-027 Shared package sm3_pkg SHALL hold the state enum, SM3_BLK_WORDS=16, SM3_LEN_IDX=14, and the 0x80000000 pad constant.
REQ-028 One combinational sub-module, sm3_pad_byte_ins, SHALL perform last-word 0x80 insertion and masking; everything else stays in sm3_msg_pad.

Verification
REQ-029 "abc" (one word 0x61626300, lst, byte_num 3) -> 16 words: 0x61626380, 14x 0x00000000, 0x00000018 with lst; no gaps.
REQ-030 64 bytes of 0x61626364, last with byte_num 0 -> 32 words: 16 data, 0x80000000, 13 zeros, 0x00000000, 0x00000200 with lst on word 32.
REQ-031 56 full bytes (14 words) -> 0x80000000 at index 14, zeros through index 13 of block 2, 0x00000000, 0x000001C0 with lst; 32 words total.
REQ-032 55 bytes (last byte_num 3) -> 0x80 in byte 3 of index 13, length 0x00000000/0x000001B8 at indices 14/15; 16 words total.
REQ-033 Vld held high during padding, random vld gaps during message -> no extra words accepted, output matches the gap-free reference word sequence.
REQ-034 rst pulsed during S_ZERO -> vld/lst low next cycle, rdy high, and a following "abc" message produces REQ-029 output exactly.
